// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: one request at a time, ack after LATENCY cycles.
// stall_o freezes the pipeline from acceptance until the ack cycle.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic [31:0]     mem [DEPTH];

  // Upper address bits only alias the array; they are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[AW+1:2];
          wdata_d = wdata_i;
          err_d   = (addr_i[1:0] != 2'b00);
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CW'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign ack_o   = (state_q == RESP);
  assign err_o   = ack_o & err_q;
  assign rdata_o = (ack_o && !we_q && !err_q) ? mem[idx_q] : 32'h0;
  assign stall_o = ((state_q == IDLE) && req_i) || (state_q == WAIT);

  // Reset in the RESP cycle aborts the store, so the write is gated by rst_i.
  assign mem_we = ack_o && we_q && !err_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_data_mem_responder;
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req4 = 1'b0, we4 = 1'b0;
  logic [31:0] addr4 = '0, wdata4 = '0;
  logic        ack4, err4, stall4;
  logic [31:0] rdata4;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ack1, err1, stall1;
  logic [31:0] rdata1;

  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we4), .addr_i(addr4), .wdata_i(wdata4),
    .ack_o(ack4), .rdata_o(rdata4), .err_o(err4), .stall_o(stall4)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
  );

  // Scoreboard side: every ack outside reset pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL ack4_unexpected: got ack with empty scoreboard, want no ack");
      end else begin
        e = q4.pop_front();
        if (err4 !== e.err || (!e.we && rdata4 !== (e.err ? 32'h0 : e.rdata))) begin
          errors++;
          $display("FAIL ack4_resp: got err=%0b rdata=%h, want err=%0b rdata=%h",
                   err4, rdata4, e.err, e.err ? 32'h0 : e.rdata);
        end
      end
    end
    if (!rst && ack1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL ack1_unexpected: got ack with empty scoreboard, want no ack");
      end else begin
        e = q1.pop_front();
        if (err1 !== e.err || (!e.we && rdata1 !== (e.err ? 32'h0 : e.rdata))) begin
          errors++;
          $display("FAIL ack1_resp: got err=%0b rdata=%h, want err=%0b rdata=%h",
                   err1, rdata1, e.err, e.err ? 32'h0 : e.rdata);
        end
      end
    end
  end

  task automatic access4(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, output int lat, output int stl);
    exp_t e;
    @(posedge clk); #1;
    req4 = 1'b1; we4 = w; addr4 = a; wdata4 = d;
    e.we = w; e.rdata = er; e.err = ee;
    q4.push_back(e);
    lat = -1; stl = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      stl += int'(stall4);
      if (ack4) begin lat = c; break; end
    end
    req4 = 1'b0;
  endtask

  task automatic access1(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, output int lat, output int stl);
    exp_t e;
    @(posedge clk); #1;
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    e.we = w; e.rdata = er; e.err = 1'b0;
    q1.push_back(e);
    lat = -1; stl = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      stl += int'(stall1);
      if (ack1) begin lat = c; break; end
    end
    req1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack4, err4, stall4, rdata4} !== 35'h0) begin
      errors++;
      $display("FAIL reset_dut4: got ack=%0b err=%0b stall=%0b rdata=%h, want all 0",
               ack4, err4, stall4, rdata4);
    end
    checks++;
    if ({ack1, err1, stall1, rdata1} !== 35'h0) begin
      errors++;
      $display("FAIL reset_dut1: got ack=%0b err=%0b stall=%0b rdata=%h, want all 0",
               ack1, err1, stall1, rdata1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    int lat, stl;
    access4(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, lat, stl);
    checks++;
    if (lat !== 4 || stl !== 4) begin
      errors++;
      $display("FAIL store_timing: got ack cycle %0d stall cycles %0d, want 4 and 4", lat, stl);
    end
    access4(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, lat, stl);
    checks++;
    if (lat !== 4 || stl !== 4) begin
      errors++;
      $display("FAIL load_timing: got ack cycle %0d stall cycles %0d, want 4 and 4", lat, stl);
    end
  endtask

  task automatic test_wrap;
    int lat, stl;
    access4(1'b1, 32'h004, 32'h1234, 32'h0, 1'b0, lat, stl);
    access4(1'b0, 32'h404, 32'h0, 32'h1234, 1'b0, lat, stl);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL wrap_timing: got ack cycle %0d, want 4", lat);
    end
  endtask

  task automatic test_misaligned;
    int lat, stl;
    access4(1'b1, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, lat, stl);
    access4(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, lat, stl);
    access4(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, lat, stl);
    checks++;
    if (lat !== 4 || stl !== 4) begin
      errors++;
      $display("FAIL misaligned_timing: got ack cycle %0d stall cycles %0d, want 4 and 4", lat, stl);
    end
  endtask

  task automatic test_reset_abort;
    int lat, stl;
    access4(1'b1, 32'h20, 32'h1111, 32'h0, 1'b0, lat, stl);
    // Abort in WAIT (cycle 2).
    @(posedge clk); #1;
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h20; wdata4 = 32'hAAAA;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req4 = 1'b0;
    @(negedge clk);
    checks++;
    if (ack4 !== 1'b0 || stall4 !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_idle: got ack=%0b stall=%0b, want 0 0", ack4, stall4);
    end
    repeat (5) @(posedge clk);
    // Abort coinciding with RESP (cycle 4).
    #1;
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h20; wdata4 = 32'hBBBB;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req4 = 1'b0;
    access4(1'b0, 32'h20, 32'h0, 32'h1111, 1'b0, lat, stl);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL abort_reload_timing: got ack cycle %0d, want 4", lat);
    end
  endtask

  task automatic test_latency1;
    int lat, stl;
    logic [3:0] stall_pat, ack_pat;
    exp_t e;
    access1(1'b1, 32'h0, 32'h77, 32'h0, lat, stl);
    checks++;
    if (lat !== 1 || stl !== 1) begin
      errors++;
      $display("FAIL lat1_store_timing: got ack cycle %0d stall cycles %0d, want 1 and 1", lat, stl);
    end
    access1(1'b1, 32'h4, 32'h88, 32'h0, lat, stl);
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
    e.we = 1'b0; e.err = 1'b0;
    e.rdata = 32'h77; q1.push_back(e);
    e.rdata = 32'h88; q1.push_back(e);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      stall_pat[c] = stall1;
      ack_pat[c]   = ack1;
      if (c == 1) addr1 = 32'h4;
    end
    req1 = 1'b0;
    checks++;
    if (stall_pat !== 4'b0101 || ack_pat !== 4'b1010) begin
      errors++;
      $display("FAIL lat1_held_req: got stall(c3..c0)=%b ack=%b, want 0101 1010", stall_pat, ack_pat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ack_pat;
    int stl;
    exp_t e;
    @(posedge clk); #1;
    req4 = 1'b1; we4 = 1'b0; addr4 = 32'h10;
    e.we = 1'b0; e.err = 1'b0;
    e.rdata = 32'hDEADBEEF; q4.push_back(e);
    e.rdata = 32'h1111;     q4.push_back(e);
    ack_pat = '0; stl = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ack_pat[c] = ack4;
      stl += int'(stall4);
      if (c == 4) addr4 = 32'h20;
    end
    req4 = 1'b0;
    checks++;
    if (ack_pat !== 16'h0210 || stl !== 8) begin
      errors++;
      $display("FAIL back_to_back: got ack mask %h stall cycles %0d, want 0210 and 8", ack_pat, stl);
    end
  endtask

  task automatic test_latched_fields;
    int lat, stl;
    exp_t e;
    access4(1'b1, 32'h40, 32'h99, 32'h0, 1'b0, lat, stl);
    @(posedge clk); #1;
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h30; wdata4 = 32'h55;
    e.we = 1'b1; e.rdata = 32'h0; e.err = 1'b0;
    q4.push_back(e);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin addr4 = 32'h40; wdata4 = 32'h66; we4 = 1'b0; end
      if (ack4) begin lat = c; break; end
    end
    req4 = 1'b0;
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latched_timing: got ack cycle %0d, want 4", lat);
    end
    access4(1'b0, 32'h30, 32'h0, 32'h55, 1'b0, lat, stl);
    access4(1'b0, 32'h40, 32'h0, 32'h99, 1'b0, lat, stl);
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_wrap;
    test_misaligned;
    test_reset_abort;
    test_latency1;
    test_back_to_back;
    test_latched_fields;
    repeat (3) @(posedge clk);
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending responses, want 0/0", q4.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
